clint_ctrl: RTL

Core-local interrupt/trap sequencer and the initiator side of the CSR file's clint port. It detects ecall, ebreak, mret and asynchronous interrupts, and stalls the pipeline while it works. It writes mepc, mstatus and mcause in sequence, then issues a one-cycle redirect to mtvec (trap) or mepc (mret) toward ctrl/pc.

---
 rtl/clint_ctrl_pkg.sv | 60 ++++++
 rtl/clint_trap_decode.sv | 46 ++++
 rtl/clint_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/clint_ctrl_pkg.sv
// Shared constants and types for the core-local trap sequencer.
// Covers CSR addresses, SYSTEM instruction encodings, cause codes,
// the trigger and FSM enums, and the mstatus rewrite helpers.
package clint_ctrl_pkg;

  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  typedef enum logic [1:0] {
    TRIG_NONE,
    TRIG_SYNC,
    TRIG_MRET,
    TRIG_ASYNC
  } trig_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MEPC,
    S_W_MSTATUS,
    S_W_MCAUSE,
    S_W_MRET,
    S_ASSERT
  } state_e;

  // CSR addresses are 12 bits and are presented zero-extended on the port.
  function automatic logic [31:0] csr_addr(input logic [11:0] a);
    return {20'b0, a};
  endfunction

  // Trap entry: MPIE takes the old MIE, then MIE is cleared.
  function automatic logic [31:0] mstatus_trap(input logic [31:0] ms);
    logic [31:0] r;
    r = ms;
    r[MSTATUS_MPIE_BIT] = ms[MSTATUS_MIE_BIT];
    r[MSTATUS_MIE_BIT]  = 1'b0;
    return r;
  endfunction

  // Trap return: MIE is restored from MPIE, then MPIE is set.
  function automatic logic [31:0] mstatus_mret(input logic [31:0] ms);
    logic [31:0] r;
    r = ms;
    r[MSTATUS_MIE_BIT]  = ms[MSTATUS_MPIE_BIT];
    r[MSTATUS_MPIE_BIT] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/clint_trap_decode.sv
// Combinational trigger decode: classifies the ID-stage instruction and
// the pending interrupts into SYNC / MRET / ASYNC. It also picks the cause
// and the return address. Priority is SYNC > MRET > ASYNC.
module clint_trap_decode
  import clint_ctrl_pkg::*;
#(
  parameter int          INT_W      = 8,
  parameter logic [31:0] MCAUSE_INT = 32'h8000_0007
) (
  input  logic [31:0]    inst_i,
  input  logic [31:0]    inst_addr_i,
  input  logic           jump_flag_i,
  input  logic [31:0]    jump_addr_i,
  input  logic           hold_i,
  input  logic [INT_W-1:0] int_flag_i,
  input  logic           global_int_en_i,
  output trig_e          trig,
  output logic [31:0]    cause,
  output logic [31:0]    epc
);

  // Synchronous traps resume after the faulting instruction. Interrupts
  // resume at the instruction that would have run next, and that is the
  // EX redirect target whenever a branch is resolving in the same cycle.
  always_comb begin
    trig  = TRIG_NONE;
    cause = '0;
    epc   = '0;
    if (inst_i == INST_ECALL) begin
      trig  = TRIG_SYNC;
      cause = CAUSE_ECALL;
      epc   = inst_addr_i + 32'd4;
    end else if (inst_i == INST_EBREAK) begin
      trig  = TRIG_SYNC;
      cause = CAUSE_EBREAK;
      epc   = inst_addr_i + 32'd4;
    end else if (inst_i == INST_MRET) begin
      trig  = TRIG_MRET;
    end else if ((|int_flag_i) && global_int_en_i && !hold_i) begin
      trig  = TRIG_ASYNC;
      cause = MCAUSE_INT;
      epc   = jump_flag_i ? jump_addr_i : inst_addr_i;
    end
  end

endmodule

// File: rtl/clint_ctrl.sv
// Core-local interrupt/trap sequencer and the initiator side of the CSR
// clint port. On a trigger it stalls the pipeline and writes the CSRs in
// this order: mepc, mstatus, mcause (or only mstatus for mret). It then
// pulses int_assert_o with the redirect target.
// Optional feature macro: CLINT_VECTORED_EN. When it is defined, async
// traps with mtvec mode 01 are vectored to base + 4*cause.
module clint_ctrl
  import clint_ctrl_pkg::*;
#(
  parameter int          INT_W      = 8,
  parameter logic [31:0] MCAUSE_INT = 32'h8000_0007
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_i,
  input  logic [31:0]      inst_addr_i,
  input  logic             jump_flag_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             hold_i,
  input  logic [INT_W-1:0] int_flag_i,
  input  logic             global_int_en_i,
  input  logic [31:0]      csr_mtvec_i,
  input  logic [31:0]      csr_mepc_i,
  input  logic [31:0]      csr_mstatus_i,
  output logic             we_o,
  output logic [31:0]      waddr_o,
  output logic [31:0]      raddr_o,
  output logic [31:0]      data_o,
  output logic             hold_o,
  output logic             int_assert_o,
  output logic [31:0]      int_addr_o
);

  state_e      state;
  trig_e       trig;
  logic [31:0] cause;
  logic [31:0] epc;
  logic [31:0] cause_q;
  logic        mret_q;
`ifdef CLINT_VECTORED_EN
  logic        async_q;
`endif

  clint_trap_decode #(
    .INT_W      (INT_W),
    .MCAUSE_INT (MCAUSE_INT)
  ) u_decode (
    .inst_i          (inst_i),
    .inst_addr_i     (inst_addr_i),
    .jump_flag_i     (jump_flag_i),
    .jump_addr_i     (jump_addr_i),
    .hold_i          (hold_i),
    .int_flag_i      (int_flag_i),
    .global_int_en_i (global_int_en_i),
    .trig            (trig),
    .cause           (cause),
    .epc             (epc)
  );

  assign raddr_o = '0;

  // Stall in the trigger cycle (combinational), then through the ASSERT cycle.
  // The decoder output only matters while the FSM is IDLE.
  assign hold_o = rst && ((state != S_IDLE) || (trig != TRIG_NONE));

  // Sequencer. The outputs are registered against the state being entered,
  // so every write strobe lines up with its state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      cause_q      <= '0;
      mret_q       <= 1'b0;
`ifdef CLINT_VECTORED_EN
      async_q      <= 1'b0;
`endif
      we_o         <= 1'b0;
      waddr_o      <= '0;
      data_o       <= '0;
      int_assert_o <= 1'b0;
    end else begin
      we_o         <= 1'b0;
      waddr_o      <= '0;
      data_o       <= '0;
      int_assert_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (trig == TRIG_SYNC || trig == TRIG_ASYNC) begin
            state   <= S_W_MEPC;
            cause_q <= cause;
            mret_q  <= 1'b0;
`ifdef CLINT_VECTORED_EN
            async_q <= (trig == TRIG_ASYNC);
`endif
            we_o    <= 1'b1;
            waddr_o <= csr_addr(CSR_MEPC);
            data_o  <= epc;
          end else if (trig == TRIG_MRET) begin
            state   <= S_W_MRET;
            mret_q  <= 1'b1;
            we_o    <= 1'b1;
            waddr_o <= csr_addr(CSR_MSTATUS);
            data_o  <= mstatus_mret(csr_mstatus_i);
          end
        end
        S_W_MEPC: begin
          state   <= S_W_MSTATUS;
          we_o    <= 1'b1;
          waddr_o <= csr_addr(CSR_MSTATUS);
          data_o  <= mstatus_trap(csr_mstatus_i);
        end
        S_W_MSTATUS: begin
          state   <= S_W_MCAUSE;
          we_o    <= 1'b1;
          waddr_o <= csr_addr(CSR_MCAUSE);
          data_o  <= cause_q;
        end
        S_W_MCAUSE, S_W_MRET: begin
          state        <= S_ASSERT;
          int_assert_o <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // The redirect target is taken from the live CSR inputs in the ASSERT cycle.
  always_comb begin
    int_addr_o = '0;
    if (int_assert_o) begin
      if (mret_q) begin
        int_addr_o = csr_mepc_i;
      end else begin
        int_addr_o = {csr_mtvec_i[31:2], 2'b00};
`ifdef CLINT_VECTORED_EN
        if (async_q && csr_mtvec_i[1:0] == 2'b01)
          int_addr_o = {csr_mtvec_i[31:2], 2'b00} + {cause_q[29:0], 2'b00};
`endif
      end
    end
  end

endmodule
